ioctl_rom_router: RTL and testbench
===================================

Name: ioctl_rom_router

Overview:
- Parametrised download router between the HPS ioctl stream and an arcade core.
- Demultiplexes ROM bytes into NUM_REGIONS equal-sized ROM regions, each with its own registered write strobe.
- Captures DIP-switch bytes from the MRA stream into a DIP bank.
- Owns the core reset sequence: reset is held during download and for a programmable number of cycles afterwards.

Parameters:
- NUM_REGIONS, 4, number of ROM regions (power of two, 1..16)
- REGION_AW, 14, address width of each region; region select = dn_addr[REGION_AW +: log2(NUM_REGIONS)]
- DIP_BYTES, 8, DIP bank depth in bytes (1..8)
- DIP_DEFAULT, 64'h0, DIP bank value after RESET
- ROM_INDEX, 0, ioctl index carrying ROM data
- DIP_INDEX, 254, ioctl index carrying DIP bytes
- RST_HOLD, 255, reset-stretch length in CLK cycles (1..65535)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- dn_ld  in  1  ioctl download active
- dn_index  in  8  ioctl index
- dn_addr  in  25  ioctl byte address
- dn_data  in  8  ioctl byte
- dn_wr  in  1  ioctl write strobe, one CLK wide
- reset_req  in  1  OR of user/menu reset sources
- rom_addr  out  REGION_AW  registered address within region
- rom_data  out  8  registered data byte
- rom_wr  out  NUM_REGIONS  one-hot registered region write strobe
- dipsw  out  DIP_BYTES*8  DIP bank; byte n at [8n+7:8n]
- core_reset  out  1  reset to the core
- dn_done  out  1  one-cycle pulse when a load completes and the core leaves reset
- dn_err  out  1  sticky: ROM write outside all regions
- rom_sum  out  16  ROM byte checksum (see Optional Feature)

Behaviour:
- RESET values: state=HOLD, hold counter=RST_HOLD, rom_wr=0, rom_addr=0, rom_data=0, dipsw=DIP_DEFAULT, core_reset=1, dn_done=0, dn_err=0, rom_sum=0.
- States: LOADING, HOLD, RUN. Edge detect on a registered copy of dn_ld.
- Transitions:
  - dn_ld rise from any state -> LOADING; clears dn_err and rom_sum.
  - LOADING with dn_ld low (fall) -> HOLD; counter=RST_HOLD.
  - HOLD: counter decrements each cycle; at 0 -> RUN. dn_done pulses on that cycle only if HOLD was entered from LOADING.
  - RUN with reset_req=1 -> HOLD; counter=RST_HOLD.
  - HOLD with reset_req=1 reloads the counter every cycle, so reset is stretched RST_HOLD cycles after the last reset_req.
  - reset_req in LOADING is ignored (state unchanged).
- core_reset = (state != RUN), registered. Combinationally ORed with RESET only.
- ROM writes:
  - Accepted when dn_wr & dn_ld & dn_index==ROM_INDEX.
  - If dn_addr[24:REGION_AW+log2(NUM_REGIONS)] == 0: next cycle rom_wr[sel]=1 for exactly one cycle, rom_addr=dn_addr[REGION_AW-1:0], rom_data=dn_data. Latency is 1 cycle.
  - Otherwise the byte is dropped (rom_wr stays 0) and dn_err is set.
  - rom_addr/rom_data hold their value between writes.
- DIP writes:
  - Accepted when dn_wr & dn_ld & dn_index==DIP_INDEX & dn_addr < DIP_BYTES; updates byte dn_addr on the next cycle.
  - Addresses >= DIP_BYTES are silently ignored and do not set dn_err.
  - dipsw is never cleared by a download start.
- Other indices, or dn_wr with dn_ld low: ignored.
- Back-to-back dn_wr every cycle is supported with no drops.
- A write on the same cycle as a dn_ld rise is accepted and is counted after the clear.
- RESET asserted mid-load: state returns to HOLD immediately; any pending rom_wr is cancelled.

Optional Feature:
- Macro: IOCTL_ROM_ROUTER_CHECKSUM_EN.
- Defined: rom_sum accumulates a 16-bit wrap-around sum of every accepted in-range ROM byte. It updates in the same cycle rom_wr asserts, clears on dn_ld rise, and holds through HOLD/RUN.
- Undefined: rom_sum is tied to 16'h0 and no adder is synthesised.

Decomposition:
- Package ioctl_router_pkg contains:
  - state enum (LOADING, HOLD, RUN)
  - localparams ROM_INDEX_DEF=0, DIP_INDEX_DEF=254
  - function clog2_sel for region-select width
- Sub-module rst_hold_counter: 16-bit loadable down-counter with load, enable and zero flag; used for the HOLD stretch.

Test Plan:
- RESET release with no download -> core_reset stays 1 for 255 cycles, then 0; dn_done stays 0.
- Load ROM_INDEX bytes at addr 0x0000, 0x4001, 0xC0FF with NUM_REGIONS=4, REGION_AW=14 -> rom_wr=0001 addr 0x0000, rom_wr=0010 addr 0x0001, rom_wr=1000 addr 0x00FF, each 1 cycle after dn_wr. After dn_ld falls, dn_done pulses once RST_HOLD cycles later.
- Write addr 0x10000 at index 0 -> no rom_wr, dn_err=1. Next dn_ld rise -> dn_err=0.
- DIP_INDEX writes addr 0..7 with data 8'hA0+n, then addr 8 -> dipsw=64'hA7A6A5A4A3A2A1A0; addr 8 has no effect and dn_err=0.
- In RUN, pulse reset_req for 3 cycles -> core_reset=1 immediately, then returns to 0 exactly 255 cycles after reset_req drops; dn_done stays 0.
- With CHECKSUM_EN, load bytes 0xFF, 0xFF, 0x02 -> rom_sum=0x0200. A new dn_ld rise clears it to 0. Without the macro, rom_sum=0 throughout.

Source files
------------

// File: rtl/ioctl_router_pkg.sv
// Shared types and helpers for the ioctl download router: FSM state
// encoding, default ioctl indices and the region-select width function.
package ioctl_router_pkg;

    typedef enum logic [1:0] {
        LOADING = 2'd0,
        HOLD    = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

    // Number of address bits needed to pick one of n regions (0 for n == 1).
    function automatic int unsigned clog2_sel(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 5; i++) begin
            if ((32'd1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rst_hold_counter.sv
// 16-bit loadable down-counter that times the core reset stretch.
// Load has priority over enable; the count saturates at zero.
module rst_hold_counter #(
    parameter logic [15:0] LOAD_VAL = 16'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    output logic [15:0] count,
    output logic        zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= LOAD_VAL;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/ioctl_rom_router.sv
// ioctl download router: ROM region demux, DIP bank capture and core reset
// sequencing. Define IOCTL_ROM_ROUTER_CHECKSUM_EN to build the rom_sum adder.
module ioctl_rom_router
    import ioctl_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 4,
    parameter int unsigned REGION_AW   = 14,
    parameter int unsigned DIP_BYTES   = 8,
    parameter logic [63:0] DIP_DEFAULT = 64'h0,
    parameter logic [7:0]  ROM_INDEX   = ROM_INDEX_DEF,
    parameter logic [7:0]  DIP_INDEX   = DIP_INDEX_DEF,
    parameter int unsigned RST_HOLD    = 255
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     dn_ld,
    input  logic [7:0]               dn_index,
    input  logic [24:0]              dn_addr,
    input  logic [7:0]               dn_data,
    input  logic                     dn_wr,
    input  logic                     reset_req,
    output logic [REGION_AW-1:0]     rom_addr,
    output logic [7:0]               rom_data,
    output logic [NUM_REGIONS-1:0]   rom_wr,
    output logic [DIP_BYTES*8-1:0]   dipsw,
    output logic                     core_reset,
    output logic                     dn_done,
    output logic                     dn_err,
    output logic [15:0]              rom_sum,
    output state_t                   dbg_state
);

    localparam int unsigned SEL_W  = clog2_sel(NUM_REGIONS);
    localparam int unsigned SEL_VW = (SEL_W == 0) ? 1 : SEL_W;
    localparam int unsigned HI_LSB = REGION_AW + SEL_W;

    state_t state, state_next;
    logic   dn_ld_r, ld_rise;
    logic   from_load, from_load_next;
    logic   done_next, core_reset_q;
    logic   cnt_load, cnt_en, hold_zero;
    logic [15:0] hold_cnt;

    logic              rom_acc, in_range, dip_acc;
    logic [SEL_VW-1:0] sel;

    assign ld_rise  = dn_ld & ~dn_ld_r;
    assign rom_acc  = dn_wr & dn_ld & (dn_index == ROM_INDEX);
    assign dip_acc  = dn_wr & dn_ld & (dn_index == DIP_INDEX) & (dn_addr < 25'(DIP_BYTES));
    assign in_range = ((dn_addr >> HI_LSB) == 25'd0);
    assign sel      = SEL_VW'(dn_addr >> REGION_AW);

    rst_hold_counter #(
        .LOAD_VAL (16'(RST_HOLD))
    ) u_hold (
        .clk   (CLK),
        .rst   (RESET),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (hold_cnt),
        .zero  (hold_zero)
    );

    // A download start wins over everything; reset_req is ignored while loading.
    always_comb begin
        state_next     = state;
        from_load_next = from_load;
        cnt_load       = 1'b0;
        cnt_en         = 1'b0;
        done_next      = 1'b0;
        if (ld_rise) begin
            state_next     = LOADING;
            from_load_next = 1'b0;
        end else begin
            case (state)
                LOADING: begin
                    if (!dn_ld) begin
                        state_next     = HOLD;
                        cnt_load       = 1'b1;
                        from_load_next = 1'b1;
                    end
                end
                HOLD: begin
                    if (reset_req) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (hold_zero || hold_cnt == 16'd1) begin
                            state_next     = RUN;
                            done_next      = from_load;
                            from_load_next = 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (reset_req) begin
                        state_next     = HOLD;
                        cnt_load       = 1'b1;
                        from_load_next = 1'b0;
                    end
                end
                default: state_next = HOLD;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= HOLD;
            dn_ld_r      <= 1'b0;
            from_load    <= 1'b0;
            dn_done      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state        <= state_next;
            dn_ld_r      <= dn_ld;
            from_load    <= from_load_next;
            dn_done      <= done_next;
            core_reset_q <= (state_next != RUN);
        end
    end

    assign core_reset = core_reset_q | RESET;
    assign dbg_state  = state;

    // Set beats clear so a bad write on the rising cycle still flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rom_wr   <= '0;
            rom_addr <= '0;
            rom_data <= 8'h00;
            dn_err   <= 1'b0;
        end else begin
            rom_wr <= '0;
            if (rom_acc && in_range) begin
                rom_wr   <= NUM_REGIONS'(1) << sel;
                rom_addr <= dn_addr[REGION_AW-1:0];
                rom_data <= dn_data;
            end
            if (rom_acc && !in_range) begin
                dn_err <= 1'b1;
            end else if (ld_rise) begin
                dn_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dipsw <= DIP_DEFAULT[DIP_BYTES*8-1:0];
        end else if (dip_acc) begin
            for (int i = 0; i < DIP_BYTES; i++) begin
                if (dn_addr == 25'(i)) dipsw[8*i +: 8] <= dn_data;
            end
        end
    end

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rom_sum <= 16'h0;
        end else if (ld_rise) begin
            rom_sum <= (rom_acc && in_range) ? {8'h00, dn_data} : 16'h0;
        end else if (rom_acc && in_range) begin
            rom_sum <= rom_sum + {8'h00, dn_data};
        end
    end
`else
    assign rom_sum = 16'h0;
`endif

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router: reset stretch, ROM demux, error flag,
// DIP capture, reset_req stretching, checksum and asynchronous reset mid-load.
module tb_ioctl_rom_router;
    import ioctl_router_pkg::*;

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        dn_ld = 1'b0;
    logic [7:0]  dn_index = 8'd0;
    logic [24:0] dn_addr = 25'd0;
    logic [7:0]  dn_data = 8'd0;
    logic        dn_wr = 1'b0;
    logic        reset_req = 1'b0;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rom_wr;
    logic [63:0] dipsw;
    logic        core_reset, dn_done, dn_err;
    logic [15:0] rom_sum;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    bit early, seen;

    ioctl_rom_router dut (
        .CLK(CLK), .RESET(RESET), .dn_ld(dn_ld), .dn_index(dn_index),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .reset_req(reset_req),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_wr(rom_wr), .dipsw(dipsw),
        .core_reset(core_reset), .dn_done(dn_done), .dn_err(dn_err),
        .rom_sum(rom_sum), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        dn_wr = 1'b1; dn_index = idx; dn_addr = a; dn_data = d;
        tick();
        dn_wr = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_rom_wr", 64'(rom_wr), 64'd0);
        chk("rst_dipsw", dipsw, 64'h0);
        chk("rst_done_err", {62'd0, dn_done, dn_err}, 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(HOLD));
        chk("rst_sum", 64'(rom_sum), 64'd0);

        // Reset stretch with no download: 255 cycles
        RESET = 1'b0;
        early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (!core_reset) early = 1'b1;
            if (dn_done) seen = 1'b1;
        end
        chk("stretch_early_release", 64'(early), 64'd0);
        tick();
        chk("stretch_release", 64'(core_reset), 64'd0);
        chk("stretch_state", 64'(dbg_state), 64'(RUN));
        chk("stretch_no_done", 64'({seen, dn_done}), 64'd0);

        // ROM download into regions 0, 1, 3
        dn_ld = 1'b1;
        tick();
        chk("load_core_reset", 64'(core_reset), 64'd1);
        chk("load_state", 64'(dbg_state), 64'(LOADING));
        wr(8'd0, 25'h0000, 8'h11);
        chk("r0_wr", 64'(rom_wr), 64'b0001);
        chk("r0_addr_data", {rom_addr, rom_data}, {14'h0000, 8'h11});
        tick();
        chk("r0_pulse_end", 64'(rom_wr), 64'd0);
        chk("r0_addr_hold", 64'(rom_addr), 64'h0000);
        dn_wr = 1'b1; dn_index = 8'd0; dn_addr = 25'h4001; dn_data = 8'h22;
        tick();
        chk("r1_wr", 64'(rom_wr), 64'b0010);
        chk("r1_addr_data", {rom_addr, rom_data}, {14'h0001, 8'h22});
        dn_addr = 25'hC0FF; dn_data = 8'h33;
        tick();
        dn_wr = 1'b0;
        chk("r3_wr", 64'(rom_wr), 64'b1000);
        chk("r3_addr_data", {rom_addr, rom_data}, {14'h00FF, 8'h33});
        chk("sum_66", 64'(rom_sum), CK ? 64'h66 : 64'h0);
        tick();
        chk("r3_pulse_end", 64'(rom_wr), 64'd0);

        // Out-of-range and foreign-index writes
        wr(8'd0, 25'h10000, 8'h44);
        chk("oor_no_wr", 64'(rom_wr), 64'd0);
        chk("oor_err", 64'(dn_err), 64'd1);
        wr(8'd5, 25'h0002, 8'h55);
        chk("other_idx_no_wr", 64'(rom_wr), 64'd0);
        chk("err_sticky", 64'(dn_err), 64'd1);

        // Load end: dn_done exactly RST_HOLD cycles after the fall
        dn_ld = 1'b0;
        tick();
        chk("fall_state", 64'(dbg_state), 64'(HOLD));
        early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (!core_reset) early = 1'b1;
            if (dn_done) seen = 1'b1;
        end
        chk("done_early", 64'({early, seen}), 64'd0);
        tick();
        chk("done_pulse", 64'({dn_done, core_reset}), 64'b10);
        tick();
        chk("done_one_cycle", 64'(dn_done), 64'd0);
        chk("err_survives_hold", 64'(dn_err), 64'd1);

        // New load clears dn_err and rom_sum; checksum wrap-around
        dn_ld = 1'b1;
        tick();
        chk("rise_clears_err", 64'(dn_err), 64'd0);
        chk("rise_clears_sum", 64'(rom_sum), 64'd0);
        dn_wr = 1'b1; dn_index = 8'd0;
        dn_addr = 25'h0000; dn_data = 8'hFF; tick();
        dn_addr = 25'h0001; dn_data = 8'hFF; tick();
        dn_addr = 25'h0002; dn_data = 8'h02; tick();
        dn_wr = 1'b0;
        chk("sum_0200", 64'(rom_sum), CK ? 64'h0200 : 64'h0);

        // Write on the same cycle as a rise counts after the clear
        dn_ld = 1'b0;
        tick();
        dn_ld = 1'b1;
        wr(8'd0, 25'h8005, 8'h05);
        chk("rise_wr", 64'(rom_wr), 64'b0100);
        chk("rise_wr_addr", 64'(rom_addr), 64'h0005);
        chk("rise_wr_sum", 64'(rom_sum), CK ? 64'h0005 : 64'h0);
        chk("rise_wr_state", 64'(dbg_state), 64'(LOADING));

        // DIP bank capture, address 8 ignored
        dn_wr = 1'b1; dn_index = 8'd254;
        for (int n = 0; n < 8; n++) begin
            dn_addr = 25'(n); dn_data = 8'hA0 + 8'(n);
            tick();
        end
        dn_addr = 25'd8; dn_data = 8'hEE;
        tick();
        dn_wr = 1'b0;
        chk("dip_bank", dipsw, 64'hA7A6A5A4A3A2A1A0);
        chk("dip_no_err", 64'(dn_err), 64'd0);
        chk("dip_no_rom_wr", 64'(rom_wr), 64'd0);

        // dn_wr with dn_ld low is ignored
        dn_ld = 1'b0;
        tick();
        wr(8'd254, 25'd0, 8'h55);
        chk("dip_ld_low", dipsw, 64'hA7A6A5A4A3A2A1A0);
        seen = 1'b0;
        for (int i = 0; i < 300 && core_reset; i++) begin
            tick();
            if (dn_done) seen = 1'b1;
        end
        chk("run_reached", 64'(core_reset), 64'd0);
        chk("run_done_seen", 64'(seen), 64'd1);

        // reset_req in RUN: 3-cycle pulse, stretch 255 after it drops
        tick();
        reset_req = 1'b1;
        tick();
        chk("rreq_core_reset", 64'(core_reset), 64'd1);
        tick(); tick();
        reset_req = 1'b0;
        early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (!core_reset) early = 1'b1;
            if (dn_done) seen = 1'b1;
        end
        chk("rreq_early", 64'(early), 64'd0);
        tick();
        chk("rreq_release", 64'(core_reset), 64'd0);
        chk("rreq_no_done", 64'({seen, dn_done}), 64'd0);

        // reset_req ignored while loading; dipsw kept across download start
        dn_ld = 1'b1;
        tick();
        reset_req = 1'b1;
        tick(); tick();
        reset_req = 1'b0;
        chk("rreq_in_load", 64'(dbg_state), 64'(LOADING));
        chk("dip_kept", dipsw, 64'hA7A6A5A4A3A2A1A0);

        // Asynchronous RESET cancels a pending rom_wr
        wr(8'd0, 25'h0003, 8'h77);
        chk("pre_reset_wr", 64'(rom_wr), 64'b0001);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rom_wr", 64'(rom_wr), 64'd0);
        chk("async_state", 64'(dbg_state), 64'(HOLD));
        chk("async_core_reset", 64'(core_reset), 64'd1);
        chk("async_dipsw", dipsw, 64'h0);
        dn_ld = 1'b0;
        tick();
        RESET = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
